// File: rtl/mul_seq_pkg.sv
// Shared definitions for the shift-add multiplier.
//   DEF_D_W     : default operand width (product is 2*DEF_D_W bits)
//   DEF_LOG2_DW : bit-index width for the default operand width
//   state_t     : FSM states (IDLE accepts operands, STEP adds partial products)
package mul_seq_pkg;
  localparam int DEF_D_W     = 32;
  localparam int DEF_LOG2_DW = $clog2(DEF_D_W);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_STEP = 1'b1
  } state_t;
endpackage

// File: rtl/mul_seq_if.sv
// Operand/product bundle for mul_seq.
// Ports (signals):
//   in_valid     : source has an operand pair
//   in_ready     : multiplier is idle and will take the pair
//   multiplicand : unsigned operand A (D_W bits)
//   multiplier   : unsigned operand B (D_W bits)
//   product      : A*B (2*D_W bits), held until the next completion
//   out_valid    : one-cycle completion pulse
// Handshake: a pair transfers on a rising clock edge where in_valid and
// in_ready are both high. in_valid while in_ready is low is ignored and not
// queued; the source holds or re-presents its operands. The output side has
// no back-pressure: product must be taken in the cycle out_valid is high.
interface mul_seq_if #(
  parameter int D_W = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [D_W-1:0]     multiplicand;
  logic [D_W-1:0]     multiplier;
  logic [2*D_W-1:0]   product;
  logic               out_valid;

  modport master (
    output in_valid, multiplicand, multiplier,
    input  in_ready, product, out_valid
  );

  modport slave (
    input  in_valid, multiplicand, multiplier,
    output in_ready, product, out_valid
  );
endinterface

// File: rtl/mul_seq_lopd.sv
// Leading-one position detector.
// Ports:
//   i_vec : input vector (D_W bits)
//   o_idx : index of the most significant set bit; don't-care when i_vec==0
module mul_seq_lopd #(
  parameter int D_W   = 32,
  parameter int OUT_W = $clog2(D_W)
) (
  input  logic [D_W-1:0]   i_vec,
  output logic [OUT_W-1:0] o_idx
);
  // Ascending scan: the last set bit seen, i.e. the highest, wins.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < D_W; i++) begin
      if (i_vec[i]) o_idx = OUT_W'(i);
    end
  end
endmodule

// File: rtl/mul_seq.sv
// Iterative unsigned shift-add multiplier.
// Each set bit of the multiplier, MSB first, adds one shifted copy of the
// multiplicand into a 2*D_W accumulator; the bit is then cleared. When no
// bits remain the accumulator is published with a one-cycle out_valid.
// Latency from acceptance edge to completion edge is popcount(B)+1.
// Ports:
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset (aborts any transaction)
//   bus     : operand/product bundle (slave side)
//   o_state : current FSM state, for observation
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int D_W = DEF_D_W
) (
  input  logic        clk,
  input  logic        rst_n,
  mul_seq_if.slave    bus,
  output state_t      o_state
);
  localparam int LOG2_DW = $clog2(D_W);

  state_t             r_state;
  state_t             w_next;
  logic [D_W-1:0]     r_a;
  logic [D_W-1:0]     r_b;
  logic [2*D_W-1:0]   r_acc;
  logic [2*D_W-1:0]   r_product;
  logic               r_out_valid;

  logic [LOG2_DW-1:0] w_msb;
  logic               w_b_nz;
  logic [2*D_W-1:0]   w_pp;
  logic [D_W-1:0]     w_clr_mask;

  mul_seq_lopd #(
    .D_W   (D_W),
    .OUT_W (LOG2_DW)
  ) u_lopd (
    .i_vec (r_b),
    .o_idx (w_msb)
  );

  assign w_b_nz     = |r_b;
  assign w_pp       = {{D_W{1'b0}}, r_a} << w_msb;
  assign w_clr_mask = {{(D_W-1){1'b0}}, 1'b1} << w_msb;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.in_valid) w_next = ST_STEP;
      ST_STEP: if (!w_b_nz)      w_next = ST_IDLE;
      default:                   w_next = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, accumulation, result publication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_product   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_a   <= bus.multiplicand;
            r_b   <= bus.multiplier;
            r_acc <= '0;
          end
        end
        ST_STEP: begin
          if (w_b_nz) begin
            // Sum of all partial products is < 2^(2*D_W): no overflow.
            r_acc <= r_acc + w_pp;
            r_b   <= r_b & ~w_clr_mask;
          end else begin
            r_product   <= r_acc;
            r_out_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // The completion cycle is already spent in IDLE, so a new pair can be
  // accepted while out_valid is high.
  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.product   = r_product;
  assign bus.out_valid = r_out_valid;
  assign o_state       = r_state;
endmodule

// File: tb/tb_mul_seq.sv
module tb_mul_seq;
  import mul_seq_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t st8;
  state_t st32;

  mul_seq_if #(.D_W(8))  bus8 ();
  mul_seq_if #(.D_W(32)) bus32 ();

  mul_seq #(.D_W(8)) u_dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus8),
    .o_state (st8)
  );

  mul_seq #(.D_W(32)) u_dut32 (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus32),
    .o_state (st32)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Presents a pair at the falling edge; it is taken at the next rising edge.
  task automatic send8(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus8.multiplicand = a;
    bus8.multiplier   = b;
    bus8.in_valid     = 1'b1;
    @(posedge clk);
    #1;
    bus8.in_valid     = 1'b0;
  endtask

  // Called 1 time unit after the acceptance edge; counts edges until out_valid.
  task automatic wait_done8(output logic [15:0] prod, output int lat,
                            output int rdy_low, output bit ok);
    lat = 0; rdy_low = 0; ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      if (!bus8.in_ready) rdy_low++;
      @(posedge clk);
      #1;
      lat++;
      if (bus8.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    prod = bus8.product;
  endtask

  task automatic run8(input string name, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp_prod, input int exp_lat);
    logic [15:0] prod;
    logic [15:0] exp;
    int          lat;
    int          rdy_low;
    bit          ok;
    send8(a, b);
    exp_q.push_back(exp_prod);
    wait_done8(prod, lat, rdy_low, ok);
    exp = exp_q.pop_front();
    check({name, "_done"}, 64'(ok), 64'd1);
    if (ok) begin
      check({name, "_product"}, 64'(prod), 64'(exp));
      check({name, "_latency"}, 64'(lat), 64'(exp_lat));
      check({name, "_busy_cycles"}, 64'(rdy_low), 64'(exp_lat));
      @(posedge clk);
      #1;
      check({name, "_single_pulse"}, 64'(bus8.out_valid), 64'd0);
      check({name, "_product_hold"}, 64'(bus8.product), 64'(exp));
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [15:0] prod;
    int          lat;
    int          rdy_low;
    bit          ok;
    int          pulses;
    logic [7:0]  ra;
    logic [7:0]  rb;

    vecs[0] = '{a: 8'd13,  b: 8'd11,  prod: 16'd143,   lat: 4};
    vecs[1] = '{a: 8'd200, b: 8'd0,   prod: 16'd0,     lat: 1};
    vecs[2] = '{a: 8'd0,   b: 8'd77,  prod: 16'd0,     lat: 5};
    vecs[3] = '{a: 8'd255, b: 8'd255, prod: 16'd65025, lat: 9};
    vecs[4] = '{a: 8'd1,   b: 8'd128, prod: 16'd128,   lat: 2};
    vecs[5] = '{a: 8'd128, b: 8'd1,   prod: 16'd128,   lat: 2};
    vecs[6] = '{a: 8'd170, b: 8'd85,  prod: 16'd14450, lat: 5};
    vecs[7] = '{a: 8'd7,   b: 8'd254, prod: 16'd1778,  lat: 8};

    bus8.in_valid      = 1'b0;
    bus8.multiplicand  = '0;
    bus8.multiplier    = '0;
    bus32.in_valid     = 1'b0;
    bus32.multiplicand = '0;
    bus32.multiplier   = '0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready",  64'(bus8.in_ready),  64'd1);
    check("reset_out_valid", 64'(bus8.out_valid), 64'd0);
    check("reset_product",   64'(bus8.product),   64'd0);
    check("reset_state",     64'(st8),            64'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      run8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].lat);
    end

    // Back-to-back: second pair offered in the out_valid cycle of the first,
    // then a stray in_valid with other operands while the second is in STEP.
    send8(8'd6, 8'd5);
    wait_done8(prod, lat, rdy_low, ok);
    check("b2b_first_done",    64'(ok),   64'd1);
    check("b2b_first_product", 64'(prod), 64'd30);
    check("b2b_first_latency", 64'(lat),  64'd3);
    bus8.multiplicand = 8'd9;
    bus8.multiplier   = 8'd3;
    bus8.in_valid     = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_second_accepted", 64'(bus8.in_ready), 64'd0);
    bus8.multiplicand = 8'd200;
    bus8.multiplier   = 8'd200;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    wait_done8(prod, lat, rdy_low, ok);
    check("b2b_second_done",    64'(ok),   64'd1);
    check("b2b_second_product", 64'(prod), 64'd27);
    check("b2b_second_latency", 64'(lat + 1), 64'd3);
    pulses = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus8.out_valid) pulses++;
    end
    check("b2b_dropped_pulse", 64'(pulses), 64'd0);

    // Reset mid-STEP
    send8(8'd100, 8'd127);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_product",   64'(bus8.product),   64'd0);
    check("midrst_in_ready",  64'(bus8.in_ready),  64'd1);
    check("midrst_out_valid", 64'(bus8.out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus8.out_valid) pulses++;
    end
    check("midrst_no_pulse",       64'(pulses),       64'd0);
    check("midrst_product_after",  64'(bus8.product), 64'd0);
    run8("post_reset", 8'd3, 8'd3, 16'd9, 3);

    // Full-width case on the 32-bit instance
    @(negedge clk);
    bus32.multiplicand = 32'hFFFF_FFFF;
    bus32.multiplier   = 32'hFFFF_FFFF;
    bus32.in_valid     = 1'b1;
    @(posedge clk);
    #1;
    bus32.in_valid = 1'b0;
    lat = 0;
    ok  = 1'b0;
    for (int n = 0; n < 80; n++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus32.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("w32_done",    64'(ok),            64'd1);
    check("w32_product", bus32.product,      64'hFFFF_FFFE_0000_0001);
    check("w32_latency", 64'(lat),           64'd33);

    // Random pairs against a multiply reference
    for (int i = 0; i < 2000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run8("rand", ra, rb, 16'(ra) * 16'(rb), $countones(rb) + 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
